// File: rtl/multicycle_ctrl_if.sv
// Instruction and data memory request/acknowledge handshakes between the
// multi-cycle controller (master) and the memory subsystem (slave).
interface multicycle_ctrl_if;
    logic imem_req;
    logic imem_ack;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ack;

    modport master (
        output imem_req,
        output dmem_req,
        output dmem_we,
        input  imem_ack,
        input  dmem_ack
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        input  dmem_we,
        output imem_ack,
        output dmem_ack
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences FETCH/DECODE/EXEC/MEM/WB around a
// shared datapath and traps on illegal opcodes or memory request timeouts.
module multicycle_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned RETIRE_W       = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    multicycle_ctrl_if.master   mem,
    input  logic [6:0]          opcode,
    input  logic [2:0]          funct3,
    input  logic                branch_cond,
    output logic                ir_we,
    output logic                alu_src_a,
    output logic                alu_src_b,
    output logic [1:0]          alu_op,
    output logic [2:0]          alu_funct3,
    output logic [2:0]          imm_sel,
    output logic                alu_out_we,
    output logic                rf_we,
    output logic [1:0]          wb_sel,
    output logic                pc_we,
    output logic [1:0]          pc_sel,
    output logic                trap,
    output logic [1:0]          trap_cause,
    output logic [RETIRE_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_BOOT, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    typedef enum logic [3:0] {
        C_NONE, C_LUI, C_AUIPC, C_JAL, C_JALR, C_BRANCH,
        C_LOAD, C_STORE, C_OPIMM, C_OP
    } class_t;

    localparam logic [2:0]  IMM_I     = 3'b000;
    localparam logic [2:0]  IMM_S     = 3'b001;
    localparam logic [2:0]  IMM_B     = 3'b010;
    localparam logic [2:0]  IMM_U     = 3'b011;
    localparam logic [2:0]  IMM_J     = 3'b100;
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t                state_reg;
    class_t                class_reg;
    logic [15:0]           wait_reg;
    logic                  trap_reg;
    logic [1:0]            cause_reg;
    logic [RETIRE_W-1:0]   instret_reg;
    class_t                opcode_class;
    logic                  is_store;
    logic                  imem_req_c;
    logic                  dmem_req_c;
    logic                  dmem_we_c;

    function automatic class_t classify(input logic [6:0] op);
        case (op)
            7'b0110111: return C_LUI;
            7'b0010111: return C_AUIPC;
            7'b1101111: return C_JAL;
            7'b1100111: return C_JALR;
            7'b1100011: return C_BRANCH;
            7'b0000011: return C_LOAD;
            7'b0100011: return C_STORE;
            7'b0010011: return C_OPIMM;
            7'b0110011: return C_OP;
            default:    return C_NONE;
        endcase
    endfunction

    assign opcode_class = classify(opcode);
    assign is_store     = (class_reg == C_STORE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_BOOT;
            class_reg   <= C_NONE;
            wait_reg    <= '0;
            trap_reg    <= 1'b0;
            cause_reg   <= 2'b00;
            instret_reg <= '0;
        end else begin
            // The wait counter only survives across unacknowledged FETCH/MEM cycles.
            wait_reg <= '0;
            case (state_reg)
                S_BOOT: state_reg <= S_FETCH;
                S_FETCH: begin
                    if (mem.imem_ack) begin
                        state_reg <= S_DECODE;
                    end else if (wait_reg == WAIT_LAST) begin
                        state_reg <= S_TRAP;
                        trap_reg  <= 1'b1;
                        cause_reg <= 2'b10;
                    end else begin
                        wait_reg <= wait_reg + 16'd1;
                    end
                end
                S_DECODE: begin
                    if (opcode_class == C_NONE) begin
                        state_reg <= S_TRAP;
                        trap_reg  <= 1'b1;
                        cause_reg <= 2'b01;
                    end else begin
                        class_reg <= opcode_class;
                        state_reg <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (class_reg == C_BRANCH) begin
                        instret_reg <= instret_reg + RETIRE_W'(1);
                        state_reg   <= S_FETCH;
                    end else if (class_reg == C_LOAD || class_reg == C_STORE) begin
                        state_reg <= S_MEM;
                    end else begin
                        state_reg <= S_WB;
                    end
                end
                S_MEM: begin
                    if (mem.dmem_ack) begin
                        if (is_store) begin
                            instret_reg <= instret_reg + RETIRE_W'(1);
                            state_reg   <= S_FETCH;
                        end else begin
                            state_reg <= S_WB;
                        end
                    end else if (wait_reg == WAIT_LAST) begin
                        state_reg <= S_TRAP;
                        trap_reg  <= 1'b1;
                        cause_reg <= 2'b11;
                    end else begin
                        wait_reg <= wait_reg + 16'd1;
                    end
                end
                S_WB: begin
                    instret_reg <= instret_reg + RETIRE_W'(1);
                    state_reg   <= S_FETCH;
                end
                S_TRAP:  state_reg <= S_TRAP;
                default: state_reg <= S_BOOT;
            endcase
        end
    end

    always_comb begin
        imem_req_c = 1'b0;
        dmem_req_c = 1'b0;
        dmem_we_c  = 1'b0;
        ir_we      = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 1'b0;
        alu_op     = 2'b00;
        alu_funct3 = 3'b000;
        imm_sel    = IMM_I;
        alu_out_we = 1'b0;
        rf_we      = 1'b0;
        wb_sel     = 2'b00;
        pc_we      = 1'b0;
        pc_sel     = 2'b00;
        case (state_reg)
            S_FETCH: begin
                imem_req_c = 1'b1;
                ir_we      = mem.imem_ack;
            end
            S_EXEC: begin
                alu_out_we = 1'b1;
                alu_funct3 = funct3;
                case (class_reg)
                    C_LUI:    begin alu_op = 2'b11; imm_sel = IMM_U; end
                    C_AUIPC:  begin alu_src_a = 1'b1; alu_src_b = 1'b1; imm_sel = IMM_U; end
                    C_JAL:    begin alu_src_a = 1'b1; alu_src_b = 1'b1; imm_sel = IMM_J; end
                    C_JALR:   begin alu_src_b = 1'b1; imm_sel = IMM_I; end
                    C_BRANCH: begin
                        alu_op  = 2'b01;
                        imm_sel = IMM_B;
                        pc_we   = 1'b1;
                        pc_sel  = branch_cond ? 2'b01 : 2'b00;
                    end
                    C_LOAD:   begin alu_src_b = 1'b1; imm_sel = IMM_I; end
                    C_STORE:  begin alu_src_b = 1'b1; imm_sel = IMM_S; end
                    C_OPIMM:  begin alu_src_b = 1'b1; alu_op = 2'b10; imm_sel = IMM_I; end
                    C_OP:     alu_op = 2'b10;
                    default:  ;
                endcase
            end
            S_MEM: begin
                dmem_req_c = 1'b1;
                dmem_we_c  = is_store;
                pc_we      = is_store && mem.dmem_ack;
            end
            S_WB: begin
                rf_we  = 1'b1;
                pc_we  = 1'b1;
                wb_sel = (class_reg == C_LOAD) ? 2'b01 :
                         (class_reg == C_JAL || class_reg == C_JALR) ? 2'b10 : 2'b00;
                pc_sel = (class_reg == C_JAL)  ? 2'b01 :
                         (class_reg == C_JALR) ? 2'b10 : 2'b00;
            end
            default: ;
        endcase
    end

    assign mem.imem_req = imem_req_c;
    assign mem.dmem_req = dmem_req_c;
    assign mem.dmem_we  = dmem_we_c;
    assign trap         = trap_reg;
    assign trap_cause   = cause_reg;
    assign instret      = instret_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: table of instruction vectors plus
// hand-written trap/reset sequences, compared cycle by cycle via a scoreboard.
module tb_multicycle_ctrl;

    localparam int K_WB = 0;
    localparam int K_BR = 1;
    localparam int K_LD = 2;
    localparam int K_ST = 3;
    localparam logic [6:0] JUNK = 7'h00;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        branch_cond;
    logic        ir_we, alu_src_a, alu_src_b, alu_out_we, rf_we, pc_we, trap;
    logic [1:0]  alu_op, wb_sel, pc_sel, trap_cause;
    logic [2:0]  alu_funct3, imm_sel;
    logic [31:0] instret;

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(.TIMEOUT_CYCLES(4), .RETIRE_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .mem(bus),
        .opcode(opcode), .funct3(funct3), .branch_cond(branch_cond),
        .ir_we(ir_we), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .alu_funct3(alu_funct3), .imm_sel(imm_sel),
        .alu_out_we(alu_out_we), .rf_we(rf_we), .wb_sel(wb_sel),
        .pc_we(pc_we), .pc_sel(pc_sel), .trap(trap), .trap_cause(trap_cause),
        .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        imem_req, ir_we, dmem_req, dmem_we, a, b;
        logic [1:0]  op;
        logic [2:0]  f3;
        logic [2:0]  imm;
        logic        alu_we, rf_we;
        logic [1:0]  wb_sel;
        logic        pc_we;
        logic [1:0]  pc_sel;
        logic        trap;
        logic [1:0]  cause;
        logic [31:0] instret;
    } exp_t;

    typedef struct {
        exp_t  e;
        string tag;
    } sb_t;

    typedef struct {
        string      name;
        logic [6:0] opc;
        logic [2:0] f3;
        logic       bc;
        int         iwait;
        int         dwait;
        logic       stray;
        logic       a;
        logic       b;
        logic [1:0] op;
        logic [2:0] imm;
        logic [1:0] wb;
        logic [1:0] pcs;
        int         kind;
    } vec_t;

    sb_t         sb_q[$];
    vec_t        vt[14];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_instret;
    exp_t        act;

    assign act = {bus.imem_req, ir_we, bus.dmem_req, bus.dmem_we, alu_src_a, alu_src_b,
                  alu_op, alu_funct3, imm_sel, alu_out_we, rf_we, wb_sel, pc_we, pc_sel,
                  trap, trap_cause, instret};

    function automatic vec_t mkv(input string name, input logic [6:0] opc, input logic [2:0] f3,
                                 input logic bc, input int iwait, input int dwait, input logic stray,
                                 input logic a, input logic b, input logic [1:0] op,
                                 input logic [2:0] imm, input logic [1:0] wb,
                                 input logic [1:0] pcs, input int kind);
        vec_t v;
        v.name = name; v.opc = opc; v.f3 = f3; v.bc = bc; v.iwait = iwait; v.dwait = dwait;
        v.stray = stray; v.a = a; v.b = b; v.op = op; v.imm = imm; v.wb = wb; v.pcs = pcs;
        v.kind = kind;
        return v;
    endfunction

    function automatic exp_t base();
        exp_t e;
        e = '0;
        e.instret = exp_instret;
        return e;
    endfunction

    task automatic check_now();
        sb_t s;
        if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard: no expected entry queued");
            return;
        end
        s = sb_q.pop_front();
        n_vec++;
        if (act !== s.e) begin
            n_err++;
            $display("FAIL %s: got %h required %h", s.tag, act, s.e);
        end
    endtask

    // One clock cycle: drive inputs (caller sits at posedge+1), check at negedge.
    task automatic cyc(input logic ia, input logic da, input logic bc, input logic [6:0] opc,
                       input exp_t e, input string tag);
        sb_t s;
        bus.imem_ack = ia;
        bus.dmem_ack = da;
        branch_cond  = bc;
        opcode       = opc;
        s.e = e;
        s.tag = tag;
        sb_q.push_back(s);
        @(negedge clk);
        check_now();
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse between clock edges, then the BOOT cycle.
    task automatic reset_pulse(input string tag);
        sb_t s;
        #1;
        rst_n = 1'b0;
        #1;
        exp_instret = '0;
        s.e = base();
        s.tag = {tag, " async-reset"};
        sb_q.push_back(s);
        check_now();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1'b1, 1'b1, 1'b0, JUNK, base(), {tag, " boot"});
    endtask

    task automatic fetch_decode(input logic [6:0] opc, input string tag);
        exp_t e;
        e = base(); e.imem_req = 1'b1; e.ir_we = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, JUNK, e, {tag, " fetch"});
        cyc(1'b0, 1'b0, 1'b0, opc, base(), {tag, " decode"});
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        logic st;
        st     = (v.kind == K_ST);
        funct3 = v.f3;
        for (int i = 0; i < v.iwait; i++) begin
            e = base(); e.imem_req = 1'b1;
            cyc(1'b0, v.stray, ~v.bc, JUNK, e, {v.name, " fetch-wait"});
        end
        e = base(); e.imem_req = 1'b1; e.ir_we = 1'b1;
        cyc(1'b1, v.stray, ~v.bc, JUNK, e, {v.name, " fetch"});
        cyc(v.stray, v.stray, ~v.bc, v.opc, base(), {v.name, " decode"});
        e = base(); e.a = v.a; e.b = v.b; e.op = v.op; e.f3 = v.f3; e.imm = v.imm; e.alu_we = 1'b1;
        if (v.kind == K_BR) begin
            e.pc_we = 1'b1; e.pc_sel = v.pcs;
        end
        cyc(v.stray, v.stray, v.bc, JUNK, e, {v.name, " exec"});
        if (v.kind == K_BR) begin
            exp_instret++;
        end else begin
            if (v.kind == K_LD || st) begin
                for (int i = 0; i < v.dwait; i++) begin
                    e = base(); e.dmem_req = 1'b1; e.dmem_we = st;
                    cyc(v.stray, 1'b0, ~v.bc, JUNK, e, {v.name, " mem-wait"});
                end
                e = base(); e.dmem_req = 1'b1; e.dmem_we = st;
                if (st) begin
                    e.pc_we = 1'b1; e.pc_sel = 2'b00;
                end
                cyc(v.stray, 1'b1, ~v.bc, JUNK, e, {v.name, " mem"});
                if (st) exp_instret++;
            end
            if (!st) begin
                e = base(); e.rf_we = 1'b1; e.pc_we = 1'b1; e.wb_sel = v.wb; e.pc_sel = v.pcs;
                cyc(v.stray, v.stray, ~v.bc, JUNK, e, {v.name, " wb"});
                exp_instret++;
            end
        end
        $display("txn %s done, expected instret=%0d", v.name, exp_instret);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    initial begin
        exp_t e;
        sb_t  s;
        //            name     opcode       f3      bc   iw dw st   a     b     op     imm     wb     pcs    kind
        vt[0]  = mkv("add",   7'b0110011, 3'b000, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 2'b10, 3'b000, 2'b00, 2'b00, K_WB);
        vt[1]  = mkv("lw",    7'b0000011, 3'b010, 1'b0, 1, 3, 1'b0, 1'b0, 1'b1, 2'b00, 3'b000, 2'b01, 2'b00, K_LD);
        vt[2]  = mkv("beq_t", 7'b1100011, 3'b000, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 2'b01, 3'b010, 2'b00, 2'b01, K_BR);
        vt[3]  = mkv("beq_n", 7'b1100011, 3'b000, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 2'b01, 3'b010, 2'b00, 2'b00, K_BR);
        vt[4]  = mkv("lui",   7'b0110111, 3'b000, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 2'b11, 3'b011, 2'b00, 2'b00, K_WB);
        vt[5]  = mkv("auipc", 7'b0010111, 3'b000, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 2'b00, 3'b011, 2'b00, 2'b00, K_WB);
        vt[6]  = mkv("jal",   7'b1101111, 3'b000, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 2'b00, 3'b100, 2'b10, 2'b01, K_WB);
        vt[7]  = mkv("jalr",  7'b1100111, 3'b000, 1'b0, 0, 0, 1'b1, 1'b0, 1'b1, 2'b00, 3'b000, 2'b10, 2'b10, K_WB);
        vt[8]  = mkv("sw",    7'b0100011, 3'b010, 1'b0, 2, 0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b001, 2'b00, 2'b00, K_ST);
        vt[9]  = mkv("andi",  7'b0010011, 3'b111, 1'b0, 3, 0, 1'b0, 1'b0, 1'b1, 2'b10, 3'b000, 2'b00, 2'b00, K_WB);
        vt[10] = mkv("sb",    7'b0100011, 3'b000, 1'b0, 0, 3, 1'b1, 1'b0, 1'b1, 2'b00, 3'b001, 2'b00, 2'b00, K_ST);
        vt[11] = mkv("bne",   7'b1100011, 3'b001, 1'b1, 1, 0, 1'b1, 1'b0, 1'b0, 2'b01, 3'b010, 2'b00, 2'b01, K_BR);
        vt[12] = mkv("lbu",   7'b0000011, 3'b100, 1'b0, 0, 0, 1'b1, 1'b0, 1'b1, 2'b00, 3'b000, 2'b01, 2'b00, K_LD);
        vt[13] = mkv("sra",   7'b0110011, 3'b101, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 2'b10, 3'b000, 2'b00, 2'b00, K_WB);

        rst_n        = 1'b1;
        opcode       = JUNK;
        funct3       = 3'b000;
        branch_cond  = 1'b0;
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        exp_instret  = '0;
        #2;
        rst_n = 1'b0;
        #1;
        s.e = base();
        s.tag = "power-on reset";
        sb_q.push_back(s);
        check_now();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1'b1, 1'b1, 1'b0, JUNK, base(), "boot");

        for (int i = 0; i < 14; i++) run_vec(vt[i]);
        e = base(); e.imem_req = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, JUNK, e, "post-table fetch");

        // Illegal opcode: sticky trap, acks ignored, no further fetches.
        funct3 = 3'b000;
        e = base(); e.imem_req = 1'b1; e.ir_we = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, JUNK, e, "illegal fetch");
        cyc(1'b1, 1'b1, 1'b0, 7'b0000000, base(), "illegal decode");
        for (int i = 0; i < 20; i++) begin
            e = base(); e.trap = 1'b1; e.cause = 2'b01;
            cyc(1'b1, 1'b1, 1'b1, 7'b0110011, e, "illegal trap hold");
        end
        $display("txn illegal-opcode trap done");
        reset_pulse("illegal");

        // Fetch timeout with TIMEOUT_CYCLES=4.
        for (int i = 0; i < 4; i++) begin
            e = base(); e.imem_req = 1'b1;
            cyc(1'b0, 1'b1, 1'b0, JUNK, e, "imem timeout wait");
        end
        for (int i = 0; i < 3; i++) begin
            e = base(); e.trap = 1'b1; e.cause = 2'b10;
            cyc(1'b1, 1'b0, 1'b0, JUNK, e, "imem timeout trap");
        end
        $display("txn imem-timeout trap done");
        reset_pulse("imem timeout");

        // Store data-memory timeout.
        funct3 = 3'b010;
        fetch_decode(7'b0100011, "dmem timeout");
        e = base(); e.b = 1'b1; e.f3 = 3'b010; e.imm = 3'b001; e.alu_we = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, JUNK, e, "dmem timeout exec");
        for (int i = 0; i < 4; i++) begin
            e = base(); e.dmem_req = 1'b1; e.dmem_we = 1'b1;
            cyc(1'b0, 1'b0, 1'b0, JUNK, e, "dmem timeout wait");
        end
        for (int i = 0; i < 3; i++) begin
            e = base(); e.trap = 1'b1; e.cause = 2'b11;
            cyc(1'b1, 1'b1, 1'b0, JUNK, e, "dmem timeout trap");
        end
        $display("txn dmem-timeout trap done");
        reset_pulse("dmem timeout");

        // Retire one instruction, then reset in the middle of a load's MEM phase.
        run_vec(vt[0]);
        funct3 = 3'b010;
        fetch_decode(7'b0000011, "mid-mem");
        e = base(); e.b = 1'b1; e.f3 = 3'b010; e.imm = 3'b000; e.alu_we = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, JUNK, e, "mid-mem exec");
        e = base(); e.dmem_req = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, JUNK, e, "mid-mem wait");
        bus.dmem_ack = 1'b0;
        #1;
        s.e = base(); s.e.dmem_req = 1'b1;
        s.tag = "mid-mem before reset";
        sb_q.push_back(s);
        check_now();
        reset_pulse("mid-mem");
        e = base(); e.imem_req = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, JUNK, e, "mid-mem refetch");
        $display("txn mid-mem reset done");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the RV32I core.
- Sequences instruction fetch, decode, execute, memory and writeback around the shared datapath. That datapath is the instruction register feeding the field decoder, plus the regfile, ALU and PC.
- Consumes the decoded opcode/funct3 and the branch comparator result, and drives every datapath enable/select and both memory request handshakes.
- Detects illegal opcodes and memory timeouts, and raises a sticky trap.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles a memory request may stay unacknowledged before trapping (1..65535).
- RETIRE_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  7  decoder opcode field from the instruction register.
- funct3  in  3  decoder funct3; passed through as alu_funct3 in EXEC.
- branch_cond  in  1  comparator result for the current branch (valid in EXEC).
- imem_req  out  1  instruction fetch request.
- imem_ack  in  1  fetch data valid this cycle.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  1 = store, 0 = load (valid while dmem_req=1).
- dmem_ack  in  1  data access complete this cycle.
- ir_we  out  1  load the instruction register.
- alu_src_a  out  1  0 = rs1, 1 = PC.
- alu_src_b  out  1  0 = rs2, 1 = immediate.
- alu_op  out  2  00 add, 01 compare/sub, 10 decode funct3/funct7, 11 pass immediate.
- alu_funct3  out  3  funct3 during EXEC, else 0.
- imm_sel  out  3  000 I, 001 S, 010 B, 011 U, 100 J.
- alu_out_we  out  1  register the ALU result.
- rf_we  out  1  regfile write (the regfile ignores x0).
- wb_sel  out  2  00 ALU result, 01 memory data, 10 PC+4.
- pc_we  out  1  update PC.
- pc_sel  out  2  00 PC+4, 01 PC+imm, 10 {alu_out[31:1],0}.
- trap  out  1  sticky fault flag.
- trap_cause  out  2  00 none, 01 illegal opcode, 10 imem timeout, 11 dmem timeout.
- instret  out  RETIRE_W  retired-instruction count.

Behaviour:
- Reset:
  - rst_n low asynchronously forces state BOOT, clears the class register, wait counter, trap, trap_cause and instret.
  - All outputs are 0 while in reset; this applies mid-transaction too.
  - Outstanding memory requests are dropped; the memories tolerate request withdrawal.
- Outputs are Moore-style, decoded from state plus the latched instruction class. The only exception is the combinational terms on imem_ack, dmem_ack and branch_cond noted below.
- BOOT: all outputs 0; next state FETCH unconditionally.
- FETCH:
  - imem_req=1 and hold.
  - On imem_ack: ir_we=1 in the same cycle, go to DECODE.
  - Wait counter clears on entry and increments each unacked cycle. When it reaches TIMEOUT_CYCLES: go to TRAP, cause=10.
- DECODE:
  - Latch the class from opcode: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OPIMM 0010011, OP 0110011.
  - Any other opcode goes to TRAP, cause=01. Otherwise go to EXEC.
- EXEC: set alu_src_a/b, alu_op, imm_sel per class; alu_out_we=1.
  - Class settings:
    - LUI: op=11, U.
    - AUIPC: a=1, b=1, op=00, U.
    - JAL: a=1, b=1, J.
    - JALR: b=1, I.
    - BRANCH: op=01, B.
    - LOAD: b=1, I.
    - STORE: b=1, S.
    - OPIMM: b=1, op=10, I.
    - OP: op=10.
  - BRANCH retires here: pc_we=1, pc_sel = branch_cond ? 01 : 00, instret++, go to FETCH.
  - LOAD/STORE go to MEM; all others go to WB.
- MEM:
  - dmem_req=1; dmem_we=1 for STORE; wait counter as in FETCH, timeout goes to TRAP with cause=11.
  - On dmem_ack: LOAD goes to WB. STORE retires: pc_we=1, pc_sel=00, instret++, go to FETCH.
- WB:
  - rf_we=1; pc_we=1; instret++; next state FETCH.
  - wb_sel: 01 for LOAD, 10 for JAL/JALR, else 00.
  - pc_sel: 01 for JAL, 10 for JALR, else 00.
- TRAP: trap=1, trap_cause held, all requests and enables 0; leaves only via reset.
- Acks arriving when no request is outstanding are ignored.
- instret wraps modulo 2^RETIRE_W.
- Latency with zero-wait acks:
  - BRANCH: 3 cycles.
  - STORE: 4 cycles.
  - ALU, LUI, AUIPC, JAL, JALR: 4 cycles.
  - LOAD: 5 cycles.
  - Each wait cycle adds one.

Test Plan:
- Reset then imem_ack every cycle, fetching OP add (0x003100B3) -> BOOT, then FETCH/DECODE/EXEC/WB. rf_we=1, wb_sel=00 in cycle 4. instret=1; the next imem_req is in cycle 5.
- LW (opcode 0000011) with dmem_ack delayed 3 cycles -> dmem_req high for 4 cycles with dmem_we=0. WB wb_sel=01. Total 8 cycles; instret +1.
- BEQ twice, branch_cond=1 then 0 -> EXEC pc_sel=01 then 00. pc_we=1 both times, rf_we never asserted, 3 cycles each.
- Opcode 0000000 -> TRAP after DECODE, trap=1, cause=01. imem_req stays 0 for 20 cycles; rst_n pulse clears trap.
- TIMEOUT_CYCLES=4, imem_ack held 0 -> imem_req high 4 cycles, then trap cause=10. STORE with dmem_ack held 0 -> cause=11.
- rst_n asserted mid-MEM with dmem_req=1 -> dmem_req drops the same cycle with no clock edge. After release: BOOT then FETCH, instret=0.
